hit_judge: RTL and testbench
============================

// Module: hit_judge
// PURPOSE
//  Judgement stage downstream of the note shifter. Conditions the red/blue player buttons, compares presses against
//  the note in the judge slot (note_R_judge/note_B_judge), issues the one-cycle delete pulse back to the shifter,
//  and keeps combo, max combo, score and hit/miss counts for the display stage. Runs once per song: IDLE/PLAY/RESULT.
// PARAMETERS
//  DEBOUNCE_CYC  20'd500000  stable-input cycles before a button change is accepted (10 ms @ 50 MHz)
//  PERFECT_LO    3'd2        lowest offset graded PERFECT
//  PERFECT_HI    3'd4        highest offset graded PERFECT
//  PERFECT_PTS   16'd3       score added per PERFECT hit
//  GOOD_PTS      16'd1       score added per GOOD hit
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   asynchronous active-low reset
//  red_button     in   1   raw red button, asynchronous, active-high
//  blue_button    in   1   raw blue button, asynchronous, active-high
//  yellow_button  in   1   raw yellow button, returns RESULT to IDLE
//  song           in   2   song select; non-zero starts play
//  note_R_judge   in   1   red note present in judge slot
//  note_B_judge   in   1   blue note present in judge slot
//  offset         in   3   shifter pixel phase 0..6, used for grading
//  finish         in   1   shifter end-of-song flag
//  delete         out  1   one-cycle pulse: clear judge slot in shifter
//  combo          out  8   current combo, saturates at 255
//  max_combo      out  8   highest combo this song
//  score          out  16  accumulated score, saturates at 16'hFFFF
//  hit_cnt        out  10  hits this song
//  miss_cnt       out  10  misses + wrong presses this song
//  grade          out  2   last judgement: 0 none, 1 PERFECT, 2 GOOD, 3 MISS
//  result_valid   out  1   high in RESULT state
// BEHAVIOUR
//  Reset (rst_n low, any time incl. mid-song): state IDLE; all outputs 0; consumed flag 0; conditioners cleared.
//  Buttons: 2-FF synchroniser -> debounce counter (accept level after DEBOUNCE_CYC equal samples) -> rising-edge
//   pulse r_press/b_press/y_press, one cycle, 2+DEBOUNCE_CYC cycles after a clean raw edge.
//  FSM: IDLE -> PLAY when song!=0 (counters, grade cleared on this transition);
//   PLAY -> RESULT when finish==1; RESULT -> IDLE on y_press. Presses outside PLAY are ignored.
//  Slot tracking (PLAY): slot_busy = note_R_judge|note_B_judge; consumed set on hit, cleared when slot_busy falls.
//  Hit: r_press & note_R_judge & !consumed (or b_press & note_B_judge & !consumed). Next cycle: delete=1 for exactly
//   one cycle; combo+1 (sat 255); max_combo=max(max_combo,new combo); hit_cnt+1;
//   grade=PERFECT and score+=PERFECT_PTS if PERFECT_LO<=offset<=PERFECT_HI (offset sampled at press), else GOOD, +GOOD_PTS.
//  Wrong press: press with slot empty, wrong colour, or consumed: combo=0, miss_cnt+1, grade=MISS, no delete.
//  Miss: slot_busy falls (1->0) with consumed==0: combo=0, miss_cnt+1, grade=MISS.
//  Simultaneous r_press & b_press: a matching press wins and counts as hit; the other edge is ignored, no penalty.
//   If neither matches, one wrong press is counted (not two).
//  Miss and hit events in the same cycle (slot falls as new-note press lands): hit is applied, miss takes priority on
//   combo (combo=1 after), both counters increment.
//  Counter widths: score/hit_cnt/miss_cnt saturate, never wrap; max_combo update uses post-increment combo.
//  finish during pending delete: delete still issues, then RESULT; counts frozen in RESULT.
// STRUCTURE
//  Package hit_judge_pkg: FSM state localparams (IDLE, PLAY, RESULT), grade codes (G_NONE/G_PERFECT/G_GOOD/G_MISS),
//   note colour codes shared with the shifter (2'd1 red, 2'd2 blue).
//  Sub-module button_conditioner (sync + debounce + rising-edge pulse, param DEBOUNCE_CYC), instantiated 3x.
//  Bench overrides DEBOUNCE_CYC=4.
// TESTING
//  1 Reset mid-PLAY with combo=5 -> all outputs 0, state IDLE next cycle, delete stays 0.
//  2 song=1, red note in slot, red press at offset 3 -> delete 1 cycle, combo 1, score 3, grade PERFECT.
//  3 Red note, blue press at offset 0 -> no delete, combo 0, miss_cnt 1, grade MISS.
//  4 Ten consecutive red hits at offset 6 then slot falls unhit -> combo 10->0, max_combo 10, score 10, miss_cnt 1.
//  5 Red+blue pressed same cycle, blue note in slot -> one hit, delete once, miss_cnt unchanged.
//  6 finish=1 then yellow press -> result_valid 1 in RESULT, counts frozen; IDLE after press, song!=0 clears counts.

Source files
------------

// File: rtl/hit_judge_pkg.sv
// Shared types and codes for the judgement stage: FSM states, grade codes,
// note colour codes agreed with the shifter, and a saturating increment helper.
package hit_judge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam logic [1:0] G_NONE    = 2'd0;
  localparam logic [1:0] G_PERFECT = 2'd1;
  localparam logic [1:0] G_GOOD    = 2'd2;
  localparam logic [1:0] G_MISS    = 2'd3;

  localparam logic [1:0] NOTE_RED  = 2'd1;
  localparam logic [1:0] NOTE_BLUE = 2'd2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hit_judge_button_conditioner.sv
// Raw button -> 2-FF synchroniser -> debounce (level accepted after DEBOUNCE_CYC
// consecutive differing samples) -> one-cycle rising-edge pulse.
module button_conditioner #(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  logic        sync1_reg;
  logic        sync2_reg;
  logic        stable_reg;
  logic        stable_d_reg;
  logic [19:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      stable_reg   <= 1'b0;
      stable_d_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      sync1_reg    <= raw;
      sync2_reg    <= sync1_reg;
      stable_d_reg <= stable_reg;
      // Any sample agreeing with the accepted level restarts the count.
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == DEBOUNCE_CYC - 20'd1) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + 20'd1;
      end
    end
  end

  assign press = stable_reg & ~stable_d_reg;

endmodule

// File: rtl/hit_judge.sv
// Judgement stage: grades button presses against the note in the judge slot,
// pulses delete back to the shifter and keeps per-song combo/score/hit/miss stats.
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd500000,
  parameter logic [2:0]  PERFECT_LO   = 3'd2,
  parameter logic [2:0]  PERFECT_HI   = 3'd4,
  parameter logic [15:0] PERFECT_PTS  = 16'd3,
  parameter logic [15:0] GOOD_PTS     = 16'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        red_button,
  input  logic        blue_button,
  input  logic        yellow_button,
  input  logic [1:0]  song,
  input  logic        note_R_judge,
  input  logic        note_B_judge,
  input  logic [2:0]  offset,
  input  logic        finish,
  output logic        delete,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo,
  output logic [15:0] score,
  output logic [9:0]  hit_cnt,
  output logic [9:0]  miss_cnt,
  output logic [1:0]  grade,
  output logic        result_valid
);

  logic [2:0] raw_btn;
  logic [2:0] press_vec;

  assign raw_btn = {yellow_button, blue_button, red_button};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      button_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cond (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_btn[gi]),
        .press (press_vec[gi])
      );
    end
  endgenerate

  state_t      state_reg, state_next;
  logic        consumed_reg, consumed_next;
  logic        slot_busy_d_reg;
  logic        delete_reg, delete_next;
  logic [7:0]  combo_reg, combo_next;
  logic [7:0]  max_combo_reg, max_combo_next;
  logic [15:0] score_reg, score_next;
  logic [9:0]  hit_cnt_reg, hit_cnt_next;
  logic [9:0]  miss_cnt_reg, miss_cnt_next;
  logic [1:0]  grade_reg, grade_next;

  logic [1:0]  note_code;
  logic        in_play, start, slot_busy, slot_fall;
  logic        hit, wrong, fall_miss, perfect;
  logic [16:0] score_sum;
  logic [10:0] miss_sum;

  assign note_code = {note_B_judge, note_R_judge};
  assign in_play   = (state_reg == PLAY);
  assign start     = (state_reg == IDLE) && (song != 2'd0);
  assign slot_busy = note_R_judge | note_B_judge;
  assign slot_fall = slot_busy_d_reg & ~slot_busy;

  // With both colours pressed, a matching colour wins and the other edge is dropped.
  assign hit = in_play & ~consumed_reg &
               ((press_vec[0] & ((note_code & NOTE_RED) != 2'd0)) |
                (press_vec[1] & ((note_code & NOTE_BLUE) != 2'd0)));
  assign wrong     = in_play & (press_vec[0] | press_vec[1]) & ~hit;
  assign fall_miss = in_play & slot_fall & ~consumed_reg;
  assign perfect   = (offset >= PERFECT_LO) && (offset <= PERFECT_HI);

  assign score_sum = {1'b0, score_reg} + {1'b0, (perfect ? PERFECT_PTS : GOOD_PTS)};
  assign miss_sum  = {1'b0, miss_cnt_reg} + {10'd0, wrong} + {10'd0, fall_miss};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (song != 2'd0) state_next = PLAY;
      PLAY:    if (finish)       state_next = RESULT;
      RESULT:  if (press_vec[2]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    consumed_next  = consumed_reg;
    delete_next    = hit;
    combo_next     = combo_reg;
    max_combo_next = max_combo_reg;
    score_next     = score_reg;
    hit_cnt_next   = hit_cnt_reg;
    miss_cnt_next  = miss_cnt_reg;
    grade_next     = grade_reg;
    if (start) begin
      consumed_next  = 1'b0;
      combo_next     = '0;
      max_combo_next = '0;
      score_next     = '0;
      hit_cnt_next   = '0;
      miss_cnt_next  = '0;
      grade_next     = G_NONE;
    end else if (in_play) begin
      if (hit)            consumed_next = 1'b1;
      else if (slot_fall) consumed_next = 1'b0;
      if (hit) begin
        hit_cnt_next = (hit_cnt_reg == 10'h3FF) ? hit_cnt_reg : hit_cnt_reg + 10'd1;
        score_next   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        grade_next   = perfect ? G_PERFECT : G_GOOD;
        // A miss landing with the hit breaks the old chain; the hit starts a new one.
        combo_next   = fall_miss ? 8'd1 : sat_inc8(combo_reg);
      end else if (wrong | fall_miss) begin
        combo_next = '0;
        grade_next = G_MISS;
      end
      miss_cnt_next  = miss_sum[10] ? 10'h3FF : miss_sum[9:0];
      max_combo_next = (combo_next > max_combo_reg) ? combo_next : max_combo_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      consumed_reg    <= 1'b0;
      slot_busy_d_reg <= 1'b0;
      delete_reg      <= 1'b0;
      combo_reg       <= '0;
      max_combo_reg   <= '0;
      score_reg       <= '0;
      hit_cnt_reg     <= '0;
      miss_cnt_reg    <= '0;
      grade_reg       <= G_NONE;
    end else begin
      state_reg       <= state_next;
      consumed_reg    <= consumed_next;
      slot_busy_d_reg <= slot_busy;
      delete_reg      <= delete_next;
      combo_reg       <= combo_next;
      max_combo_reg   <= max_combo_next;
      score_reg       <= score_next;
      hit_cnt_reg     <= hit_cnt_next;
      miss_cnt_reg    <= miss_cnt_next;
      grade_reg       <= grade_next;
    end
  end

  assign delete       = delete_reg;
  assign combo        = combo_reg;
  assign max_combo    = max_combo_reg;
  assign score        = score_reg;
  assign hit_cnt      = hit_cnt_reg;
  assign miss_cnt     = miss_cnt_reg;
  assign grade        = grade_reg;
  assign result_valid = (state_reg == RESULT);

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: hand table of note windows, directed corner sequences,
// then random note windows checked against a per-note scoring model.
module tb_hit_judge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        red_button = 1'b0;
  logic        blue_button = 1'b0;
  logic        yellow_button = 1'b0;
  logic [1:0]  song = 2'd0;
  logic        note_R_judge = 1'b0;
  logic        note_B_judge = 1'b0;
  logic [2:0]  offset = 3'd0;
  logic        finish = 1'b0;
  logic        delete;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic [15:0] score;
  logic [9:0]  hit_cnt;
  logic [9:0]  miss_cnt;
  logic [1:0]  grade;
  logic        result_valid;

  always #5 clk = ~clk;

  hit_judge #(.DEBOUNCE_CYC(20'd4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .red_button    (red_button),
    .blue_button   (blue_button),
    .yellow_button (yellow_button),
    .song          (song),
    .note_R_judge  (note_R_judge),
    .note_B_judge  (note_B_judge),
    .offset        (offset),
    .finish        (finish),
    .delete        (delete),
    .combo         (combo),
    .max_combo     (max_combo),
    .score         (score),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt),
    .grade         (grade),
    .result_valid  (result_valid)
  );

  int checks = 0;
  int errors = 0;
  int del_total = 0;
  int width_err = 0;
  logic del_prev = 1'b0;

  always @(negedge clk) begin
    if (delete) del_total <= del_total + 1;
    if (delete && del_prev) width_err <= width_err + 1;
    del_prev <= delete;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold long enough for the debounced pulse to land, then release and settle.
  task automatic push(input logic r, input logic b, input logic y);
    red_button = r; blue_button = b; yellow_button = y;
    tick(10);
    red_button = 1'b0; blue_button = 1'b0; yellow_button = 1'b0;
    tick(10);
  endtask

  task automatic set_note(input logic [1:0] c, input logic [2:0] off);
    note_R_judge = c[0]; note_B_judge = c[1]; offset = off;
    tick(1);
  endtask

  task automatic drop();
    note_R_judge = 1'b0; note_B_judge = 1'b0;
    tick(3);
  endtask

  task automatic start_song();
    song = 2'd1; tick(1); song = 2'd0; tick(1);
  endtask

  task automatic check_all(input string tag, input int c, input int mc, input int s,
                           input int h, input int m, input int g);
    check({tag, " combo"}, int'(combo), c);
    check({tag, " max_combo"}, int'(max_combo), mc);
    check({tag, " score"}, int'(score), s);
    check({tag, " hit_cnt"}, int'(hit_cnt), h);
    check({tag, " miss_cnt"}, int'(miss_cnt), m);
    check({tag, " grade"}, int'(grade), g);
  endtask

  typedef struct {
    logic [1:0] colour;
    logic       r;
    logic       b;
    logic [2:0] off;
    int         exp_del;
    int         exp_grade;
    int         exp_combo;
    int         exp_score;
    int         exp_miss;
  } vec_t;

  vec_t vecs[8];

  // Reference model state for the random phase.
  int m_combo, m_max, m_score, m_hit, m_miss, m_grade;

  initial begin
    int d0;
    vecs[0] = '{2'd1, 1'b1, 1'b0, 3'd3, 1, 1, 1, 3, 0};
    vecs[1] = '{2'd1, 1'b0, 1'b1, 3'd0, 0, 3, 0, 3, 1};
    vecs[2] = '{2'd2, 1'b1, 1'b1, 3'd5, 1, 2, 1, 4, 2};
    vecs[3] = '{2'd2, 1'b0, 1'b1, 3'd2, 1, 1, 2, 7, 2};
    vecs[4] = '{2'd0, 1'b1, 1'b0, 3'd4, 0, 3, 0, 7, 3};
    vecs[5] = '{2'd1, 1'b1, 1'b0, 3'd6, 1, 2, 1, 8, 3};
    vecs[6] = '{2'd1, 1'b1, 1'b1, 3'd1, 1, 2, 2, 9, 3};
    vecs[7] = '{2'd2, 1'b1, 1'b0, 3'd4, 0, 3, 0, 9, 4};

    tick(3);
    rst_n = 1'b1;
    tick(1);
    check_all("reset", 0, 0, 0, 0, 0, 0);
    check("reset result_valid", int'(result_valid), 0);
    check("reset delete", int'(delete), 0);

    start_song();
    check("play result_valid", int'(result_valid), 0);

    for (int i = 0; i < 8; i++) begin
      set_note(vecs[i].colour, vecs[i].off);
      d0 = del_total;
      push(vecs[i].r, vecs[i].b, 1'b0);
      check($sformatf("vec%0d delete", i), del_total - d0, vecs[i].exp_del);
      check($sformatf("vec%0d grade", i), int'(grade), vecs[i].exp_grade);
      check($sformatf("vec%0d combo", i), int'(combo), vecs[i].exp_combo);
      check($sformatf("vec%0d score", i), int'(score), vecs[i].exp_score);
      check($sformatf("vec%0d miss_cnt", i), int'(miss_cnt), vecs[i].exp_miss);
      $display("vec %0d colour=%0d r=%0d b=%0d off=%0d -> del=%0d grade=%0d combo=%0d score=%0d miss=%0d",
               i, vecs[i].colour, vecs[i].r, vecs[i].b, vecs[i].off, del_total - d0,
               grade, combo, score, miss_cnt);
      drop();
    end
    check_all("table end", 0, 2, 9, 5, 5, 3);

    // Song end: RESULT freezes counts, yellow returns to IDLE, new song clears.
    finish = 1'b1; tick(1); finish = 1'b0; tick(1);
    check("result result_valid", int'(result_valid), 1);
    set_note(2'd1, 3'd3);
    d0 = del_total;
    push(1'b1, 1'b0, 1'b0);
    drop();
    check("result delete", del_total - d0, 0);
    check_all("result frozen", 0, 2, 9, 5, 5, 3);
    push(1'b0, 1'b0, 1'b1);
    check("idle result_valid", int'(result_valid), 0);
    check_all("idle held", 0, 2, 9, 5, 5, 3);
    $display("song end: result then yellow, counts held hit=%0d miss=%0d", hit_cnt, miss_cnt);
    start_song();
    check_all("restart", 0, 0, 0, 0, 0, 0);

    // Ten red hits off the PERFECT window, then an unhit note.
    d0 = del_total;
    for (int i = 0; i < 10; i++) begin
      set_note(2'd1, 3'd6);
      push(1'b1, 1'b0, 1'b0);
      drop();
    end
    check("streak deletes", del_total - d0, 10);
    check_all("streak", 10, 10, 10, 10, 0, 2);
    set_note(2'd1, 3'd6);
    tick(5);
    drop();
    check_all("streak miss", 0, 10, 10, 10, 1, 3);
    $display("streak: 10 hits then miss combo=%0d max=%0d score=%0d miss=%0d", combo, max_combo, score, miss_cnt);

    // Reset mid-song with a live combo and a press in flight.
    for (int i = 0; i < 5; i++) begin
      set_note(2'd1, 3'd3);
      push(1'b1, 1'b0, 1'b0);
      drop();
    end
    check("pre-reset combo", int'(combo), 5);
    set_note(2'd1, 3'd3);
    red_button = 1'b1;
    tick(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all("async reset", 0, 0, 0, 0, 0, 0);
    d0 = del_total;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("post-reset result_valid", int'(result_valid), 0);
    tick(10);
    red_button = 1'b0;
    tick(10);
    drop();
    check("post-reset delete", del_total - d0, 0);
    check_all("post-reset idle", 0, 0, 0, 0, 0, 0);
    $display("reset mid-song: outputs cleared, idle press ignored");

    // Random note windows against the scoring model.
    start_song();
    m_combo = 0; m_max = 0; m_score = 0; m_hit = 0; m_miss = 0; m_grade = 0;
    for (int w = 0; w < 40; w++) begin
      logic [1:0] col;
      logic [2:0] off;
      int         npress, exp_del;
      bit         consumed;
      col = 2'($urandom_range(0, 2));
      off = 3'($urandom_range(0, 6));
      npress = $urandom_range(1, 2);
      consumed = 0;
      exp_del = 0;
      set_note(col, off);
      d0 = del_total;
      for (int p = 0; p < npress; p++) begin
        logic r, b;
        int   sel;
        sel = $urandom_range(1, 3);
        r = sel[0]; b = sel[1];
        push(r, b, 1'b0);
        if (!consumed && ((r && col == 2'd1) || (b && col == 2'd2))) begin
          consumed = 1;
          exp_del++;
          m_hit++;
          m_combo = (m_combo < 255) ? m_combo + 1 : 255;
          if (off >= 2 && off <= 4) begin m_score += 3; m_grade = 1; end
          else begin m_score += 1; m_grade = 2; end
        end else begin
          m_miss++; m_combo = 0; m_grade = 3;
        end
        if (m_combo > m_max) m_max = m_combo;
      end
      drop();
      if (col != 2'd0 && !consumed) begin
        m_miss++; m_combo = 0; m_grade = 3;
      end
      check($sformatf("rand%0d delete", w), del_total - d0, exp_del);
      check_all($sformatf("rand%0d", w), m_combo, m_max, m_score, m_hit, m_miss, m_grade);
      $display("rand %0d colour=%0d off=%0d presses=%0d -> combo=%0d max=%0d score=%0d hit=%0d miss=%0d grade=%0d",
               w, col, off, npress, combo, max_combo, score, hit_cnt, miss_cnt, grade);
    end

    check("delete pulse width", width_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
